pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DW, default 64, meaning payload width in bits (DW >= 1).
REQ-002 SHALL have parameter SBW, default 32, meaning sideband (PC-type) width in bits; sideband is not cleared on flush or bubble.
REQ-003 SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer with registered up_ready, 0 = single entry with combinational up_ready.
REQ-004 SHALL have parameter NOP_VAL, default all-zero DW bits, meaning the payload loaded on reset, flush and bubble.
REQ-005 SHALL have port clk, input, 1, meaning single clock; all state updates on its rising edge.
REQ-006 SHALL have port cpurst, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have port flush, input, 1, meaning discard all held entries.
REQ-008 SHALL have port bubble, input, 1, meaning insert one NOP entry instead of accepting upstream data.
REQ-009 SHALL have port up_valid, input, 1, meaning upstream presents an entry.
REQ-010 SHALL have port up_ready, output, 1, meaning block accepts an upstream entry this cycle.
REQ-011 SHALL have port up_data, input, DW, meaning upstream payload.
REQ-012 SHALL have port up_sb, input, SBW, meaning upstream sideband.
REQ-013 SHALL have port dn_valid, output, 1, meaning the head entry is valid.
REQ-014 SHALL have port dn_ready, input, 1, meaning downstream consumes the head this cycle.
REQ-015 SHALL have port dn_data, output, DW, meaning head payload, driven from a register.
REQ-016 SHALL have port dn_sb, output, SBW, meaning head sideband, driven from a register.
REQ-017 SHALL have port occ, output, 2, meaning number of valid entries held (0..2; max 1 when SKID=0).

Function
REQ-018 SHALL define up-transfer = up_valid & up_ready and dn-transfer = dn_valid & dn_ready; dn_valid SHALL equal the head-slot valid flag.
REQ-019 SHALL deliver entries downstream in acceptance order, with zero bubbles: an entry accepted into an empty block appears on dn_* the next cycle (latency 1).
REQ-020 SHALL, when SKID=1, drive up_ready = ~skid_full registered, independent of dn_ready in the same cycle.
REQ-021 SHALL, when SKID=1, place an up-transfer into the head slot if the head is empty or draining this cycle, otherwise into the skid slot.
REQ-022 SHALL, when SKID=1 and the head drains while the skid slot is full, move the skid entry into the head slot in the same edge and free the skid slot.
REQ-023 SHALL, when SKID=0, drive up_ready = ~head_full | dn_ready combinationally.
REQ-024 SHALL hold dn_data, dn_sb and dn_valid stable while dn_valid=1 and dn_ready=0.
REQ-025 SHALL, on bubble=1 with the block able to load (head empty or draining, skid empty), load head with payload NOP_VAL, dn_valid=1, sideband = up_sb; up_ready SHALL be 0 that cycle and no up-transfer occurs.
REQ-026 SHALL ignore bubble while the block cannot load; the bubble is not remembered.
REQ-027 SHALL, on flush=1, clear both valid flags, load head payload NOP_VAL, keep both sideband registers unchanged, and drive up_ready=0 that cycle.
REQ-028 SHALL give priority cpurst > flush > bubble > normal transfer when asserted in the same cycle.
REQ-029 SHALL update occ every edge as occ + up-transfer - dn-transfer (bubble counts as +1); occ SHALL never exceed 2 nor underflow.
REQ-030 SHALL treat simultaneous up-transfer and dn-transfer at occ=1 as occ staying 1 with head replaced by the new entry.

Reset
REQ-031 SHALL, while cpurst=1, clear both valid flags, load head and skid payloads with NOP_VAL, clear both sideband registers to 0, force occ=0 and up_ready=0.
REQ-032 SHALL drive up_ready=1 in the first cycle after cpurst deasserts; reset mid-transfer SHALL discard all entries without emitting any dn-transfer.

Verification
REQ-033 SHALL cover: SKID=1, empty, up_data=0x11 with up_valid=1 one cycle, dn_ready=1 -> dn_valid=1, dn_data=0x11 next cycle, occ=1 then 0.
REQ-034 SHALL cover: SKID=1, dn_ready=0, push 0xA1, 0xA2 -> occ=2, up_ready=0; raise dn_ready -> 0xA1 then 0xA2 consecutively, up_ready=1 after first drain.
REQ-035 SHALL cover: bubble=1 with up_valid=1, up_data=0x55, up_sb=0x1000, block empty -> dn_data=NOP_VAL, dn_sb=0x1000, dn_valid=1; 0x55 accepted the following cycle.
REQ-036 SHALL cover: occ=2 with sb 0x2000/0x2004, flush=1 -> dn_valid=0, occ=0, dn_data=NOP_VAL, dn_sb=0x2000 unchanged.
REQ-037 SHALL cover: flush=1 and bubble=1 same cycle -> flush behaviour only, dn_valid=0.
REQ-038 SHALL cover: SKID=0, head full, dn_ready=1, up_valid=1 data 0x77 -> up_ready=1 combinationally, dn_data=0x77 next cycle, occ stays 1.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with optional two-entry skid buffer, flush and NOP-bubble insertion.
// Head slot drives dn_*; the skid slot only ever holds an entry while the head is full.
module pipe_skid_stage #(
    parameter int              DW      = 64,
    parameter int              SBW     = 32,
    parameter int              SKID    = 1,
    parameter logic [DW-1:0]   NOP_VAL = '0
) (
    input  logic           clk,
    input  logic           cpurst,
    input  logic           flush,
    input  logic           bubble,
    input  logic           up_valid,
    output logic           up_ready,
    input  logic [DW-1:0]  up_data,
    input  logic [SBW-1:0] up_sb,
    output logic           dn_valid,
    input  logic           dn_ready,
    output logic [DW-1:0]  dn_data,
    output logic [SBW-1:0] dn_sb,
    output logic [1:0]     occ
);

    logic           head_valid;
    logic           skid_valid;
    logic [DW-1:0]  head_data;
    logic [DW-1:0]  skid_data;
    logic [SBW-1:0] head_sb;
    logic [SBW-1:0] skid_sb;

    logic head_free;
    logic can_load;
    logic bubble_take;
    logic space;
    logic up_xfer;

    // Valid/ready: a beat moves on a port only in a cycle where valid and ready are both high.
    assign head_free   = ~head_valid | dn_ready;
    assign can_load    = head_free & ~skid_valid;
    assign bubble_take = bubble & can_load;

    // With a skid slot, readiness comes only from registered state; without it, it follows dn_ready.
    assign space    = (SKID != 0) ? ~skid_valid : head_free;
    assign up_ready = space & ~cpurst & ~flush & ~bubble_take;
    assign up_xfer  = up_valid & up_ready;

    assign dn_valid = head_valid;
    assign dn_data  = head_data;
    assign dn_sb    = head_sb;
    assign occ      = {1'b0, head_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk) begin
        if (cpurst) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_data  <= NOP_VAL;
            skid_data  <= NOP_VAL;
            head_sb    <= '0;
            skid_sb    <= '0;
        end else if (flush) begin
            // Sideband deliberately survives a flush so the last PC stays observable.
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_data  <= NOP_VAL;
        end else if (bubble_take) begin
            head_valid <= 1'b1;
            head_data  <= NOP_VAL;
            head_sb    <= up_sb;
        end else if (head_free) begin
            if (skid_valid) begin
                head_valid <= 1'b1;
                head_data  <= skid_data;
                head_sb    <= skid_sb;
                skid_valid <= 1'b0;
            end else if (up_xfer) begin
                head_valid <= 1'b1;
                head_data  <= up_data;
                head_sb    <= up_sb;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (up_xfer && (SKID != 0)) begin
            skid_valid <= 1'b1;
            skid_data  <= up_data;
            skid_sb    <= up_sb;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: SKID=1 and SKID=0 instances share stimulus, each checked
// every cycle against its own queue model, plus directed literal checks.
module tb_pipe_skid_stage;

    localparam int          DW  = 16;
    localparam int          SBW = 16;
    localparam logic [15:0] NOP = 16'hE0E0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           cpurst, flush, bubble, up_valid, dn_ready;
    logic [DW-1:0]  up_data;
    logic [SBW-1:0] up_sb;

    logic           ur1, dv1, ur0, dv0;
    logic [DW-1:0]  dd1, dd0;
    logic [SBW-1:0] ds1, ds0;
    logic [1:0]     oc1, oc0;

    pipe_skid_stage #(.DW(DW), .SBW(SBW), .SKID(1), .NOP_VAL(NOP)) dut1 (
        .clk(clk), .cpurst(cpurst), .flush(flush), .bubble(bubble),
        .up_valid(up_valid), .up_ready(ur1), .up_data(up_data), .up_sb(up_sb),
        .dn_valid(dv1), .dn_ready(dn_ready), .dn_data(dd1), .dn_sb(ds1), .occ(oc1)
    );

    pipe_skid_stage #(.DW(DW), .SBW(SBW), .SKID(0), .NOP_VAL(NOP)) dut0 (
        .clk(clk), .cpurst(cpurst), .flush(flush), .bubble(bubble),
        .up_valid(up_valid), .up_ready(ur0), .up_data(up_data), .up_sb(up_sb),
        .dn_valid(dv0), .dn_ready(dn_ready), .dn_data(dd0), .dn_sb(ds0), .occ(oc0)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 1 = SKID=1 (capacity 2), index 0 = SKID=0 (capacity 1).
    // Each is an ordered list of held entries plus the last value shown on dn_*.
    logic [15:0] md[2][2];
    logic [15:0] ms[2][2];
    int          n[2];
    logic [15:0] hd[2];
    logic [15:0] hs[2];
    bit          model_ok = 0;

    function automatic bit m_can_load(input int k);
        return (n[k] == 0) || (n[k] == 1 && dn_ready);
    endfunction

    function automatic bit m_up_ready(input int k);
        if (cpurst || flush) return 1'b0;
        if (bubble && m_can_load(k)) return 1'b0;
        if (k == 1) return n[k] < 2;
        return (n[k] == 0) || dn_ready;
    endfunction

    task automatic m_step(input int k);
        bit ur, bub, dx;
        if (cpurst) begin
            n[k] = 0; hd[k] = NOP; hs[k] = '0;
        end else if (flush) begin
            n[k] = 0; hd[k] = NOP;
        end else begin
            ur  = m_up_ready(k);
            bub = bubble && m_can_load(k);
            dx  = (n[k] > 0) && dn_ready;
            if (dx) begin
                md[k][0] = md[k][1];
                ms[k][0] = ms[k][1];
                n[k]--;
            end
            if (bub && n[k] < 2) begin
                md[k][n[k]] = NOP; ms[k][n[k]] = up_sb; n[k]++;
            end else if (up_valid && ur && n[k] < 2) begin
                md[k][n[k]] = up_data; ms[k][n[k]] = up_sb; n[k]++;
            end
            if (n[k] > 0) begin
                hd[k] = md[k][0];
                hs[k] = ms[k][0];
            end
        end
    endtask

    always @(posedge clk) begin
        m_step(1);
        m_step(0);
        if (cpurst) model_ok = 1;
    end

    // Compare process: outputs settled, inputs stable mid-cycle.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m1_up_ready", 32'(ur1), 32'(m_up_ready(1)));
            chk("m1_dn_valid", 32'(dv1), 32'(n[1] > 0));
            chk("m1_occ",      32'(oc1), 32'(n[1]));
            chk("m1_dn_data",  32'(dd1), 32'(hd[1]));
            chk("m1_dn_sb",    32'(ds1), 32'(hs[1]));
            chk("m0_up_ready", 32'(ur0), 32'(m_up_ready(0)));
            chk("m0_dn_valid", 32'(dv0), 32'(n[0] > 0));
            chk("m0_occ",      32'(oc0), 32'(n[0]));
            chk("m0_dn_data",  32'(dd0), 32'(hd[0]));
            chk("m0_dn_sb",    32'(ds0), 32'(hs[0]));
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; bubble = 0; up_valid = 0; dn_ready = 0; cpurst = 0;
    endtask

    task automatic push(input logic [15:0] d, input logic [15:0] s);
        up_valid = 1; up_data = d; up_sb = s;
    endtask

    initial begin
        cpurst = 1; flush = 0; bubble = 0; up_valid = 0; dn_ready = 0;
        up_data = '0; up_sb = '0;

        // Reset state
        edge1(); edge1(); #1;
        chk("rst_up_ready1", 32'(ur1), 32'd0);
        chk("rst_occ1",      32'(oc1), 32'd0);
        chk("rst_dn_valid1", 32'(dv1), 32'd0);
        chk("rst_dn_data1",  32'(dd1), 32'hE0E0);
        chk("rst_dn_sb1",    32'(ds1), 32'd0);
        cpurst = 0; #1;
        chk("post_rst_up_ready1", 32'(ur1), 32'd1);
        chk("post_rst_up_ready0", 32'(ur0), 32'd1);

        // Single entry, latency 1
        push(16'h0011, 16'h0000); dn_ready = 1;
        edge1(); up_valid = 0; #1;
        chk("lat_dn_valid", 32'(dv1), 32'd1);
        chk("lat_dn_data",  32'(dd1), 32'h0011);
        chk("lat_occ1",     32'(oc1), 32'd1);
        edge1(); #1;
        chk("lat_occ0", 32'(oc1), 32'd0);
        chk("lat_dn_valid_low", 32'(dv1), 32'd0);

        // Fill skid, then drain in order
        dn_ready = 0; push(16'h00A1, 16'h0000);
        edge1(); push(16'h00A2, 16'h0000);
        edge1(); up_valid = 0; #1;
        chk("fill_occ",      32'(oc1), 32'd2);
        chk("fill_up_ready", 32'(ur1), 32'd0);
        chk("fill_head",     32'(dd1), 32'h00A1);
        dn_ready = 1; #1;
        chk("fill_ready_regd", 32'(ur1), 32'd0);
        edge1(); #1;
        chk("drain_second", 32'(dd1), 32'h00A2);
        chk("drain_valid",  32'(dv1), 32'd1);
        chk("drain_up_rdy", 32'(ur1), 32'd1);
        edge1(); #1;
        chk("drain_empty", 32'(dv1), 32'd0);
        dn_ready = 0;

        // Bubble into empty block
        bubble = 1; push(16'h0055, 16'h1000); #1;
        chk("bub_up_ready", 32'(ur1), 32'd0);
        edge1(); bubble = 0; #1;
        chk("bub_data",  32'(dd1), 32'hE0E0);
        chk("bub_sb",    32'(ds1), 32'h1000);
        chk("bub_valid", 32'(dv1), 32'd1);
        chk("bub_up_rdy_after", 32'(ur1), 32'd1);
        edge1(); up_valid = 0; #1;
        chk("bub_occ", 32'(oc1), 32'd2);
        dn_ready = 1;
        edge1(); #1;
        chk("bub_next_data", 32'(dd1), 32'h0055);
        edge1(); edge1(); dn_ready = 0;

        // Flush with two held entries
        push(16'h00B1, 16'h2000);
        edge1(); push(16'h00B2, 16'h2004);
        edge1(); up_valid = 0; #1;
        chk("fl_pre_occ", 32'(oc1), 32'd2);
        flush = 1; #1;
        chk("fl_up_ready1", 32'(ur1), 32'd0);
        chk("fl_up_ready0", 32'(ur0), 32'd0);
        edge1(); flush = 0; #1;
        chk("fl_valid", 32'(dv1), 32'd0);
        chk("fl_occ",   32'(oc1), 32'd0);
        chk("fl_data",  32'(dd1), 32'hE0E0);
        chk("fl_sb",    32'(ds1), 32'h2000);
        chk("fl_sb0",   32'(ds0), 32'h2000);

        // Flush beats bubble
        flush = 1; bubble = 1; push(16'h0099, 16'h3000);
        edge1(); idle(); #1;
        chk("flbub_valid1", 32'(dv1), 32'd0);
        chk("flbub_occ1",   32'(oc1), 32'd0);
        chk("flbub_sb1",    32'(ds1), 32'h2000);
        chk("flbub_valid0", 32'(dv0), 32'd0);

        // SKID=0 combinational ready with full head
        push(16'h0066, 16'h4000);
        edge1(); push(16'h0077, 16'h4004); #1;
        chk("s0_up_ready_blk", 32'(ur0), 32'd0);
        dn_ready = 1; #1;
        chk("s0_up_ready_comb", 32'(ur0), 32'd1);
        edge1(); idle(); #1;
        chk("s0_data",  32'(dd0), 32'h0077);
        chk("s0_occ",   32'(oc0), 32'd1);
        chk("s0_valid", 32'(dv0), 32'd1);
        chk("s1_replace_occ", 32'(oc1), 32'd1);
        dn_ready = 1; edge1(); edge1(); idle();

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            cpurst   = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 99) < 3);
            bubble   = ($urandom_range(0, 99) < 6);
            up_valid = ($urandom_range(0, 99) < 60);
            dn_ready = ($urandom_range(0, 99) < 65);
            up_data  = 16'($urandom);
            up_sb    = 16'($urandom);
            edge1();
        end
        idle();
        edge1(); edge1();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
